// File: rtl/mc6847_char_gen.sv
// Character-row generator: glyph ROM fetch, in-cell padding, inversion and MSB-first serialisation.
// Capture lands ROM_LAT clk after a load; no backpressure, a second capture over an untaken row sets sticky overrun.
module mc6847_char_gen #(
    parameter int GLYPH_W = 8,
    parameter int CELL_H  = 12,
    parameter int GLYPH_H = 8,
    parameter int TOP_PAD = 3,
    parameter int CODE_W  = 6,
    parameter int ROM_LAT = 1
) (
    input  logic                              i_clk,
    input  logic                              i_reset_n,
    input  logic                              i_clk_ena,
    input  logic                              i_load,
    input  logic [CODE_W-1:0]                 i_code,
    input  logic [3:0]                        i_row,
    input  logic                              i_inv,
    output logic [CODE_W+$clog2(GLYPH_H)-1:0] o_rom_addr,
    input  logic [GLYPH_W-1:0]                i_rom_data,
    output logic                              o_pix,
    output logic                              o_pix_valid,
    output logic                              o_overrun
);

    localparam int GA_W  = $clog2(GLYPH_H);
    localparam int CNT_W = $clog2(GLYPH_W);
    localparam logic [4:0] PAD5  = 5'(TOP_PAD);
    localparam logic [4:0] END5  = 5'(TOP_PAD + GLYPH_H);
    localparam logic [4:0] CELL5 = 5'(CELL_H);
    localparam logic [1:0] LAT   = 2'(ROM_LAT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(GLYPH_W - 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;

    logic [CODE_W+GA_W-1:0] r_rom_addr;
    logic [1:0]             r_fcnt;
    logic                   r_blank;
    logic                   r_inv;
    logic [GLYPH_W-1:0]     r_pend;
    logic                   r_pend_vld;
    logic                   r_overrun;
    logic [GLYPH_W-1:0]     r_shreg;
    logic [CNT_W-1:0]       r_cnt;
    logic [0:0]             r_state;

    logic                   w_req;
    logic [4:0]             w_row5;
    logic                   w_blank;
    logic [GA_W-1:0]        w_grow;
    logic                   w_cap;
    logic                   w_abandon;
    logic                   w_slot;
    logic                   w_take;
    logic [GLYPH_W-1:0]     w_capdat;

    assign w_req     = i_clk_ena & i_load;
    assign w_row5    = {1'b0, i_row};
    // The CELL_H term is implied by the glyph bounds but keeps out-of-cell rows blank even if those are mis-set.
    assign w_blank   = (w_row5 < PAD5) | (w_row5 >= END5) | (w_row5 >= CELL5);
    assign w_grow    = GA_W'(i_row - PAD5[3:0]);
    assign w_cap     = (r_fcnt == 2'd1);
    assign w_abandon = w_req & (r_fcnt > 2'd1);
    assign w_slot    = i_clk_ena & ((r_state == S_IDLE) | (r_cnt == LAST));
    assign w_take    = w_slot & r_pend_vld;
    assign w_capdat  = (r_blank ? '0 : i_rom_data) ^ {GLYPH_W{r_inv}};

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_rom_addr <= '0;
            r_fcnt     <= 2'd0;
            r_blank    <= 1'b0;
            r_inv      <= 1'b0;
        end else if (w_req) begin
            r_rom_addr <= {i_code, w_grow};
            r_fcnt     <= LAT;
            r_blank    <= w_blank;
            r_inv      <= i_inv;
        end else if (r_fcnt != 2'd0) begin
            r_fcnt <= r_fcnt - 2'd1;
        end
    end

    // A reload on the capture edge consumes the old row first, so the new one lands without overrun.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_pend     <= '0;
            r_pend_vld <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            if (w_cap) begin
                r_pend     <= w_capdat;
                r_pend_vld <= 1'b1;
            end else if (w_take) begin
                r_pend_vld <= 1'b0;
            end
            if (w_abandon || (w_cap && r_pend_vld && !w_take)) begin
                r_overrun <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_shreg <= '0;
            r_cnt   <= '0;
            r_state <= S_IDLE;
        end else if (w_slot) begin
            r_cnt <= '0;
            if (r_pend_vld) begin
                r_shreg <= r_pend;
                r_state <= S_SHIFT;
            end else begin
                r_shreg <= '0;
                r_state <= S_IDLE;
            end
        end else if (i_clk_ena) begin
            r_shreg <= {r_shreg[GLYPH_W-2:0], 1'b0};
            r_cnt   <= r_cnt + 1'b1;
        end
    end

    assign o_rom_addr  = r_rom_addr;
    assign o_pix       = r_shreg[GLYPH_W-1];
    assign o_pix_valid = (r_state == S_SHIFT);
    assign o_overrun   = r_overrun;

endmodule

// File: tb/tb_mc6847_char_gen.sv
// Bench for mc6847_char_gen: ROM_LAT=1 and ROM_LAT=2 builds driven in lockstep, one enable every 4 clk.
module tb_mc6847_char_gen;

    logic       clk = 1'b0;
    logic       reset_n, clk_ena, load, inv;
    logic [5:0] code;
    logic [3:0] row;
    logic [8:0] addr1, addr2;
    logic [7:0] rd1, rd2;
    logic       pix1, pv1, ov1, pix2, pv2, ov2;
    logic [7:0] mem [0:511];

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: remaining pixels of the shown character, one pending row, sticky overrun
    int         q[$];
    logic [7:0] m_pend;
    bit         m_pend_vld;
    bit         m_ovr;
    bit         e_pix, e_vld;

    always #5 clk = ~clk;

    assign rd1 = mem[addr1];
    always @(posedge clk) rd2 <= mem[addr2];

    mc6847_char_gen #(.ROM_LAT(1)) u_dut1 (
        .i_clk(clk), .i_reset_n(reset_n), .i_clk_ena(clk_ena), .i_load(load),
        .i_code(code), .i_row(row), .i_inv(inv), .o_rom_addr(addr1), .i_rom_data(rd1),
        .o_pix(pix1), .o_pix_valid(pv1), .o_overrun(ov1)
    );

    mc6847_char_gen #(.ROM_LAT(2)) u_dut2 (
        .i_clk(clk), .i_reset_n(reset_n), .i_clk_ena(clk_ena), .i_load(load),
        .i_code(code), .i_row(row), .i_inv(inv), .o_rom_addr(addr2), .i_rom_data(rd2),
        .o_pix(pix2), .o_pix_valid(pv2), .o_overrun(ov2)
    );

    function automatic logic [7:0] glyph_row(int c, int r, bit iv);
        logic [7:0] v;
        if (r < 3 || r >= 11) v = 8'h00;
        else                  v = mem[c * 8 + (r - 3)];
        return iv ? ~v : v;
    endfunction

    function automatic logic [8:0] exp_addr(int c, int r);
        return 9'(c * 8 + ((r - 3) & 7));
    endfunction

    task automatic step(input bit ld, input int c, input int r, input bit iv);
        @(negedge clk);
        clk_ena = 1'b1; load = ld; code = 6'(c); row = 4'(r); inv = iv;
        @(posedge clk);
        #1;
        clk_ena = 1'b0; load = 1'b0;
        if (q.size() == 0 && m_pend_vld) begin
            for (int i = 7; i >= 0; i--) q.push_back(int'(m_pend[i]));
            m_pend_vld = 1'b0;
        end
        if (q.size() > 0) begin e_pix = (q.pop_front() != 0); e_vld = 1'b1; end
        else              begin e_pix = 1'b0; e_vld = 1'b0; end
        if (ld) begin
            if (m_pend_vld) m_ovr = 1'b1;
            m_pend     = glyph_row(c, r, iv);
            m_pend_vld = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0; clk_ena = 1'b0; load = 1'b0;
        @(posedge clk);
        #1;
        q.delete();
        m_pend_vld = 1'b0;
        m_ovr      = 1'b0;
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({pix1, pv1, ov1, pix2, pv2, ov2} !== 6'b0 || addr1 !== 9'h0 || addr2 !== 9'h0) begin
            n_fail++;
            $display("FAIL reset_state: pix=%b/%b vld=%b/%b ovr=%b/%b addr=%h/%h, want all 0",
                     pix1, pix2, pv1, pv2, ov1, ov2, addr1, addr2);
        end
        release_reset();
    endtask

    task automatic test_basic();
        logic [7:0] pat = 8'hA5;
        logic [1:0] want;
        int nvld = 0;
        mem[9'h008] = 8'hA5;
        step(1'b1, 1, 3, 1'b0);
        n_checks++;
        if (addr1 !== 9'h008 || addr2 !== 9'h008 || pv1 !== 1'b0 || pv2 !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_addr: addr=%h/%h vld=%b/%b, want addr=008 vld=0", addr1, addr2, pv1, pv2);
        end
        for (int i = 0; i < 9; i++) begin
            step(1'b0, 0, 0, 1'b0);
            want = (i < 8) ? {pat[7-i], 1'b1} : 2'b00;
            n_checks++;
            if ({pix1, pv1} !== want || {pix2, pv2} !== want || ov1 !== 1'b0 || ov2 !== 1'b0) begin
                n_fail++;
                $display("FAIL basic_pix enable %0d: pix/vld=%b%b,%b%b ovr=%b/%b, want %b ovr=0",
                         i, pix1, pv1, pix2, pv2, ov1, ov2, want);
            end
            if (pv1 && pv2) nvld++;
        end
        n_checks++;
        if (nvld != 8) begin
            n_fail++;
            $display("FAIL basic_count: valid enables=%0d, want 8", nvld);
        end
    endtask

    task automatic test_blank_rows();
        int rows[4] = '{0, 2, 11, 15};
        for (int i = 0; i < 512; i++) mem[i] = 8'hFF;
        for (int iv = 0; iv < 2; iv++) begin
            for (int k = 0; k < 4; k++) begin
                step(1'b1, 5, rows[k], iv[0]);
                for (int p = 0; p < 9; p++) begin
                    step(1'b0, 0, 0, 1'b0);
                    n_checks++;
                    if ({pix1, pv1, pix2, pv2} !== ((p < 8) ? {iv[0], 1'b1, iv[0], 1'b1} : 4'b0)) begin
                        n_fail++;
                        $display("FAIL blank_row%0d_inv%0d pixel %0d: pix=%b/%b vld=%b/%b, want pix=%b vld=%b",
                                 rows[k], iv, p, pix1, pix2, pv1, pv2, (p < 8) && iv[0], p < 8);
                    end
                end
            end
        end
        for (int i = 0; i < 512; i++) mem[i] = 8'($urandom);
    endtask

    task automatic test_code3f();
        logic [7:0] v = 8'($urandom);
        mem[9'h1FF] = v;
        step(1'b1, 63, 10, 1'b0);
        n_checks++;
        if (addr1 !== 9'h1FF || addr2 !== 9'h1FF) begin
            n_fail++;
            $display("FAIL code3f_addr: addr=%h/%h, want 1ff", addr1, addr2);
        end
        for (int p = 0; p < 8; p++) begin
            step(1'b0, 0, 0, 1'b0);
            n_checks++;
            if ({pix1, pv1, pix2, pv2} !== {v[7-p], 1'b1, v[7-p], 1'b1}) begin
                n_fail++;
                $display("FAIL code3f_pix %0d: pix=%b/%b vld=%b/%b, want pix=%b vld=1",
                         p, pix1, pix2, pv1, pv2, v[7-p]);
            end
        end
        step(1'b0, 0, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        int  nvld = 0;
        bit  ld, want_vld;
        int  c;
        for (int e = 0; e <= 33; e++) begin
            ld = (e == 0) || (e == 6) || (e == 14) || (e == 22);
            c  = (e == 0) ? 0 : (e == 6) ? 1 : (e == 14) ? 2 : 3;
            step(ld, c, 5, 1'b0);
            want_vld = (e >= 1 && e <= 32);
            n_checks++;
            if (pv1 !== want_vld || pv2 !== want_vld || pix1 !== e_pix || pix2 !== e_pix
                || ov1 !== 1'b0 || ov2 !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b enable %0d: pix=%b/%b vld=%b/%b ovr=%b/%b, want pix=%b vld=%b ovr=0",
                         e, pix1, pix2, pv1, pv2, ov1, ov2, e_pix, want_vld);
            end
            if (pv1 && pv2) nvld++;
        end
        n_checks++;
        if (nvld != 32) begin
            n_fail++;
            $display("FAIL b2b_count: valid enables=%0d, want 32", nvld);
        end
    endtask

    task automatic test_overrun();
        logic [7:0] gb = 8'hF0;
        mem[exp_addr(20, 5)] = 8'h0F;
        mem[exp_addr(30, 6)] = gb;
        for (int e = 0; e <= 20; e++) begin
            step(e == 0 || e == 3 || e == 4, (e == 0) ? 10 : (e == 3) ? 20 : 30,
                 (e == 0) ? 4 : (e == 3) ? 5 : 6, 1'b0);
            n_checks++;
            if ({pix1, pv1, ov1} !== {e_pix, e_vld, m_ovr} || {pix2, pv2, ov2} !== {e_pix, e_vld, m_ovr}) begin
                n_fail++;
                $display("FAIL overrun_stream enable %0d: pix=%b/%b vld=%b/%b ovr=%b/%b, want %b %b %b",
                         e, pix1, pix2, pv1, pv2, ov1, ov2, e_pix, e_vld, m_ovr);
            end
            if (e >= 4) begin
                n_checks++;
                if (ov1 !== 1'b1 || ov2 !== 1'b1) begin
                    n_fail++;
                    $display("FAIL overrun_sticky enable %0d: ovr=%b/%b, want 1", e, ov1, ov2);
                end
            end
            if (e >= 9 && e <= 16) begin
                n_checks++;
                if (pix1 !== gb[16-e] || pix2 !== gb[16-e]) begin
                    n_fail++;
                    $display("FAIL overrun_second enable %0d: pix=%b/%b, want %b", e, pix1, pix2, gb[16-e]);
                end
            end
        end
    endtask

    task automatic test_random();
        bit ld, iv;
        int c, r;
        do_reset();
        release_reset();
        for (int i = 0; i < 512; i++) mem[i] = 8'($urandom);
        for (int e = 0; e < 300; e++) begin
            ld = ($urandom_range(0, 3) == 0);
            c  = $urandom_range(0, 63);
            r  = $urandom_range(0, 15);
            iv = 1'($urandom);
            step(ld, c, r, iv);
            n_checks++;
            if ({pix1, pv1, ov1} !== {e_pix, e_vld, m_ovr} || {pix2, pv2, ov2} !== {e_pix, e_vld, m_ovr}
                || (ld && (addr1 !== exp_addr(c, r) || addr2 !== exp_addr(c, r)))) begin
                n_fail++;
                $display("FAIL random enable %0d: pix=%b/%b vld=%b/%b ovr=%b/%b addr=%h/%h, want %b %b %b addr=%h",
                         e, pix1, pix2, pv1, pv2, ov1, ov2, addr1, addr2, e_pix, e_vld, m_ovr,
                         ld ? exp_addr(c, r) : addr1);
            end
        end
    endtask

    task automatic test_reset_mid();
        step(1'b1, 7, 8, 1'b0);
        for (int e = 1; e <= 4; e++) step(e == 3, 9, 6, 1'b1);
        do_reset();
        n_checks++;
        if ({pix1, pv1, ov1, pix2, pv2, ov2} !== 6'b0 || addr1 !== 9'h0 || addr2 !== 9'h0) begin
            n_fail++;
            $display("FAIL reset_mid: pix=%b/%b vld=%b/%b ovr=%b/%b addr=%h/%h, want all 0",
                     pix1, pix2, pv1, pv2, ov1, ov2, addr1, addr2);
        end
        release_reset();
        for (int e = 0; e < 12; e++) begin
            step(e == 2, 2, 4, 1'b0);
            n_checks++;
            if ({pix1, pv1, ov1} !== {e_pix, e_vld, m_ovr} || {pix2, pv2, ov2} !== {e_pix, e_vld, m_ovr}) begin
                n_fail++;
                $display("FAIL after_reset enable %0d: pix=%b/%b vld=%b/%b ovr=%b/%b, want %b %b %b",
                         e, pix1, pix2, pv1, pv2, ov1, ov2, e_pix, e_vld, m_ovr);
            end
        end
    endtask

    initial begin
        reset_n = 1'b0; clk_ena = 1'b0; load = 1'b0; code = '0; row = '0; inv = 1'b0;
        m_pend = '0; m_pend_vld = 1'b0; m_ovr = 1'b0;
        for (int i = 0; i < 512; i++) mem[i] = 8'($urandom);
        test_reset();
        test_basic();
        test_blank_rows();
        test_code3f();
        test_back_to_back();
        test_overrun();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
